// File: rtl/counter_div_param.sv
// Prescaled up/down counter with a run-time terminal value, a divided-clock
// output that toggles on every count tick, and a one-cycle terminal-count pulse.
module counter_div_param #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] counter,
  output logic             clk_d,
  output logic             tc
);

  // A 1-bit prescaler is kept even for PRESCALE=1; it then never leaves 0,
  // so every enabled edge is a tick.
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0]    psc;
  logic             tick;
  logic             wrap;
  logic [WIDTH-1:0] cnt_nxt;

  // Tick on the last prescaler phase of an enabled, non-load edge.
  always_comb begin
    tick = en && !load && (psc == PMAX);
  end

  // Next count value and wrap flag; values above max_val wrap immediately.
  always_comb begin
    wrap    = 1'b0;
    cnt_nxt = counter;
    if (up_dn) begin
      if (counter >= max_val) begin
        wrap    = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = counter + WIDTH'(1);
      end
    end else begin
      if (counter == '0 || counter > max_val) begin
        wrap    = 1'b1;
        cnt_nxt = max_val;
      end else begin
        cnt_nxt = counter - WIDTH'(1);
      end
    end
  end

  // Prescaler: cleared by reset or load, advances only on enabled edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc <= '0;
    end else if (load) begin
      psc <= '0;
    end else if (en) begin
      psc <= (psc == PMAX) ? '0 : psc + PW'(1);
    end
  end

  // Counter, divided clock and terminal-count pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      clk_d   <= 1'b0;
      tc      <= 1'b0;
    end else if (load) begin
      counter <= load_val;
      tc      <= 1'b0;
    end else if (tick) begin
      counter <= cnt_nxt;
      clk_d   <= ~clk_d;
      tc      <= wrap;
    end else begin
      tc      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_div_param.sv
// Randomized + directed bench for counter_div_param: two instances
// (WIDTH=4/PRESCALE=2 and WIDTH=8/PRESCALE=1) checked every cycle against a
// behavioural model, with literal expectations pinning key points.
module tb_counter_div_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] lv_a = '0, mx_a = 4'd9;
  logic [7:0] lv_b = '0, mx_b = 8'd255;
  logic [3:0] cnt_a;
  logic [7:0] cnt_b;
  logic       clkd_a, clkd_b, tc_a, tc_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  counter_div_param #(.WIDTH(4), .PRESCALE(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv_a), .max_val(mx_a), .counter(cnt_a), .clk_d(clkd_a), .tc(tc_a));

  counter_div_param #(.WIDTH(8), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(lv_b), .max_val(mx_b), .counter(cnt_b), .clk_d(clkd_b), .tc(tc_b));

  // Behavioural model: index 0 is instance A, index 1 is instance B.
  int m_cnt[2];
  int m_psc[2];
  bit m_clkd[2];
  bit m_tc[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int c, p, mx, lv, ps;
      bit d, t;
      c  = m_cnt[i];
      p  = m_psc[i];
      d  = m_clkd[i];
      t  = 1'b0;
      mx = (i == 0) ? int'(mx_a) : int'(mx_b);
      lv = (i == 0) ? int'(lv_a) : int'(lv_b);
      ps = (i == 0) ? 2 : 1;
      if (rst) begin
        c = 0; p = 0; d = 1'b0;
      end else if (load) begin
        c = lv; p = 0;
      end else if (en) begin
        p = p + 1;
        if (p == ps) begin
          p = 0;
          d = !d;
          if (up_dn) begin
            if (c >= mx) begin c = 0; t = 1'b1; end
            else c = c + 1;
          end else begin
            if (c == 0 || c > mx) begin c = mx; t = 1'b1; end
            else c = c - 1;
          end
        end
      end
      m_cnt[i]  <= c;
      m_psc[i]  <= p;
      m_clkd[i] <= d;
      m_tc[i]   <= t;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("cnt_a",  int'(cnt_a),  m_cnt[0]);
      cmp("clkd_a", int'(clkd_a), int'(m_clkd[0]));
      cmp("tc_a",   int'(tc_a),   int'(m_tc[0]));
      cmp("cnt_b",  int'(cnt_b),  m_cnt[1]);
      cmp("clkd_b", int'(clkd_b), int'(m_clkd[1]));
      cmp("tc_b",   int'(tc_b),   int'(m_tc[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b1; load = 1'b0; en = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    // Reset for two cycles.
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    cmp("lit_reset_cnt", int'(cnt_a), 0);
    cmp("lit_reset_clkd", int'(clkd_a), 0);
    cmp("lit_reset_tc", int'(tc_a), 0);

    // Count up to 9 and wrap, PRESCALE=2.
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; mx_a = 4'd9; mx_b = 8'd255;
    cyc(18);
    cmp("lit_up_9", int'(cnt_a), 9);
    cmp("lit_up_9_tc", int'(tc_a), 0);
    cyc(2);
    cmp("lit_wrap_0", int'(cnt_a), 0);
    cmp("lit_wrap_tc", int'(tc_a), 1);
    cyc(2);
    cmp("lit_clkd_11", int'(clkd_a), 1);
    cyc(2);
    cmp("lit_up_2", int'(cnt_a), 2);
    cmp("lit_clkd_12", int'(clkd_a), 0);
    cmp("lit_b_24", int'(cnt_b), 24);

    // Load above max_val, then wrap up and down.
    load = 1'b1; lv_a = 4'd12; lv_b = 8'd200;
    cyc(1);
    cmp("lit_load_12", int'(cnt_a), 12);
    cmp("lit_load_tc", int'(tc_a), 0);
    load = 1'b0;
    cyc(2);
    cmp("lit_load_up_wrap", int'(cnt_a), 0);
    cmp("lit_load_up_tc", int'(tc_a), 1);
    up_dn = 1'b0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(2);
    cmp("lit_load_dn_wrap", int'(cnt_a), 9);
    cmp("lit_load_dn_tc", int'(tc_a), 1);

    // Count down from reset with max_val=5.
    rst_pulse();
    en = 1'b1; up_dn = 1'b0; mx_a = 4'd5;
    cyc(2);
    cmp("lit_dn_5", int'(cnt_a), 5);
    cmp("lit_dn_5_tc", int'(tc_a), 1);
    cyc(2);
    cmp("lit_dn_4", int'(cnt_a), 4);
    cmp("lit_dn_4_tc", int'(tc_a), 0);
    cyc(8);
    cmp("lit_dn_0", int'(cnt_a), 0);
    cyc(2);
    cmp("lit_dn_rewrap", int'(cnt_a), 5);
    cmp("lit_dn_rewrap_tc", int'(tc_a), 1);

    // Freeze at counter=3, prescaler=1; resume ticks on first enabled edge.
    rst_pulse();
    en = 1'b1; up_dn = 1'b1; mx_a = 4'd9;
    cyc(7);
    en = 1'b0;
    cyc(5);
    cmp("lit_freeze_cnt", int'(cnt_a), 3);
    cmp("lit_freeze_clkd", int'(clkd_a), 1);
    en = 1'b1;
    cyc(1);
    cmp("lit_resume_tick", int'(cnt_a), 4);
    cmp("lit_resume_clkd", int'(clkd_a), 0);

    // Reset concurrent with load.
    rst_pulse();
    en = 1'b1; up_dn = 1'b1;
    cyc(12);
    cmp("lit_pre_rst_6", int'(cnt_a), 6);
    rst = 1'b1; load = 1'b1; lv_a = 4'd7;
    cyc(1);
    cmp("lit_rst_load_cnt", int'(cnt_a), 0);
    cmp("lit_rst_load_clkd", int'(clkd_a), 0);
    cmp("lit_rst_load_tc", int'(tc_a), 0);
    rst = 1'b0; load = 1'b0;

    // PRESCALE=1, WIDTH=8 full-range wrap.
    rst_pulse();
    en = 1'b1; up_dn = 1'b1; mx_b = 8'd255;
    cyc(255);
    cmp("lit_b_255", int'(cnt_b), 255);
    cmp("lit_b_255_tc", int'(tc_b), 0);
    cyc(1);
    cmp("lit_b_wrap", int'(cnt_b), 0);
    cmp("lit_b_wrap_tc", int'(tc_b), 1);
    cmp("lit_b_clkd", int'(clkd_b), 0);
    cyc(4);
    cmp("lit_b_4", int'(cnt_b), 4);

    // Randomized traffic, including max_val=0 and out-of-range loads.
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 63) == 0);
      load  = ($urandom_range(0, 15) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up_dn = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 31) == 0) begin
        mx_a = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        mx_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      end
      lv_a = 4'($urandom_range(0, 15));
      lv_b = 8'($urandom_range(0, 255));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
